// File: rtl/change_dispenser_if.sv
// Bundle of the change dispenser signals: the refund request and balance from
// the calculator, the three hopper handshakes, and the payout status.
// The dispenser takes the slave view. The surrounding datapath (or a bench)
// takes the master view.
interface change_dispenser_if;
  logic       refund_req;
  logic [9:0] balance_in;
  logic [2:0] hopper_empty;
  logic       hopper_ack;
  logic       coin50_out;
  logic       coin10_out;
  logic       coin5_out;
  logic       busy;
  logic       done;
  logic       sum_clear;
  logic [9:0] remaining;
  logic [7:0] coin_cnt;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output refund_req, balance_in, hopper_empty, hopper_ack,
    input  coin50_out, coin10_out, coin5_out, busy, done, sum_clear,
           remaining, coin_cnt, fault, fault_code
  );

  modport slave (
    input  refund_req, balance_in, hopper_empty, hopper_ack,
    output coin50_out, coin10_out, coin5_out, busy, done, sum_clear,
           remaining, coin_cnt, fault, fault_code
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: latches the balance on a refund edge and pays it out
// greedily as 50/10/5 coins through a pulse/acknowledge handshake with the
// hoppers. Empty hoppers are skipped. On completion it pulses sum_clear so the
// balance calculator zeroes its balance.
// Every output is a register loaded from the next-state values, so each output
// is aligned with the state it describes.
module change_dispenser #(
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 250,
  parameter int MAX_BAL     = 995
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_PULSE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  localparam logic [7:0] PULSE_LAST   = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LAST     = 8'(GAP_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [9:0] MAX_BAL_V    = 10'(MAX_BAL);

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_NOCOIN  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL = 2'b11;

  // A legal balance is in range and a whole number of 5-units.
  function automatic logic bal_legal(input logic [9:0] bal);
    return (bal <= MAX_BAL_V) && ((bal % 10'd5) == 10'd0);
  endfunction

  // Face value of the one-hot coin selection {50,10,5}.
  function automatic logic [9:0] coin_value(input logic [2:0] sel);
    case (sel)
      3'b100:  return 10'd50;
      3'b010:  return 10'd10;
      3'b001:  return 10'd5;
      default: return 10'd0;
    endcase
  endfunction

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [9:0] remaining_r, remaining_s;
  logic [7:0] coin_cnt_r, coin_cnt_s;
  logic [2:0] sel_r, sel_s;
  logic [1:0] fault_code_r, fault_code_s;
  logic       rq_d_r;
  logic [2:0] coin_r, coin_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       fault_r, fault_s;
  logic       edge_s;
  logic       load_s;

  assign edge_s = bus.refund_req & ~rq_d_r;

  // Next-state, datapath updates and output decode for the payout FSM.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    remaining_s  = remaining_r;
    coin_cnt_s   = coin_cnt_r;
    sel_s        = sel_r;
    fault_code_s = fault_code_r;
    load_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (edge_s) begin
          load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SELECT: begin
        cnt_s = 8'd0;
        if (remaining_r == 10'd0) begin
          state_s = ST_DONE;
        end else if ((remaining_r >= 10'd50) && !bus.hopper_empty[2]) begin
          sel_s   = 3'b100;
          state_s = ST_PULSE;
        end else if ((remaining_r >= 10'd10) && !bus.hopper_empty[1]) begin
          sel_s   = 3'b010;
          state_s = ST_PULSE;
        end else if ((remaining_r >= 10'd5) && !bus.hopper_empty[0]) begin
          sel_s   = 3'b001;
          state_s = ST_PULSE;
        end else begin
          fault_code_s = FC_NOCOIN;
          state_s      = ST_FAULT;
        end
      end

      ST_PULSE: begin
        if (cnt_r == PULSE_LAST) begin
          cnt_s   = 8'd0;
          state_s = ST_WAIT_ACK;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      ST_WAIT_ACK: begin
        if (bus.hopper_ack) begin
          remaining_s = remaining_r - coin_value(sel_r);
          coin_cnt_s  = coin_cnt_r + 8'd1;
          cnt_s       = 8'd0;
          state_s     = ST_GAP;
        end else if (cnt_r == TIMEOUT_LAST) begin
          cnt_s        = 8'd0;
          fault_code_s = FC_TIMEOUT;
          state_s      = ST_FAULT;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      ST_GAP: begin
        // The gap only advances while the hopper has released ack.
        if (!bus.hopper_ack) begin
          if (cnt_r == GAP_LAST) begin
            cnt_s   = 8'd0;
            state_s = ST_SELECT;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      ST_FAULT: begin
        if (edge_s) begin
          if (fault_code_r == FC_ILLEGAL) begin
            load_s = 1'b1;
          end else begin
            fault_code_s = FC_NONE;
            state_s      = ST_SELECT;
          end
        end else begin
          state_s = ST_FAULT;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A fresh request, from IDLE or to recover from an illegal balance.
    if (load_s) begin
      remaining_s = bus.balance_in;
      if (bal_legal(bus.balance_in)) begin
        coin_cnt_s   = 8'd0;
        fault_code_s = FC_NONE;
        state_s      = ST_SELECT;
      end else begin
        fault_code_s = FC_ILLEGAL;
        state_s      = ST_FAULT;
      end
    end else begin
      load_s = 1'b0;
    end

    coin_s  = (state_s == ST_PULSE) ? sel_s : 3'b000;
    busy_s  = (state_s != ST_IDLE);
    done_s  = (state_s == ST_DONE);
    fault_s = (state_s == ST_FAULT);
  end

  // State, datapath and registered outputs. Async reset drops the coin lines at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      remaining_r  <= 10'd0;
      coin_cnt_r   <= 8'd0;
      sel_r        <= 3'b000;
      fault_code_r <= FC_NONE;
      rq_d_r       <= 1'b0;
      coin_r       <= 3'b000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      remaining_r  <= remaining_s;
      coin_cnt_r   <= coin_cnt_s;
      sel_r        <= sel_s;
      fault_code_r <= fault_code_s;
      rq_d_r       <= bus.refund_req;
      coin_r       <= coin_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      fault_r      <= fault_s;
    end
  end

  assign bus.coin50_out = coin_r[2];
  assign bus.coin10_out = coin_r[1];
  assign bus.coin5_out  = coin_r[0];
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.sum_clear  = done_r;
  assign bus.remaining  = remaining_r;
  assign bus.coin_cnt   = coin_cnt_r;
  assign bus.fault      = fault_r;
  assign bus.fault_code = fault_code_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. A small hopper model answers each coin
// pulse with a one-cycle ack a few cycles after the pulse ends. Expected
// coin mixes, counts and latencies are worked out by hand for each vector.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  change_dispenser_if dut_if ();

  change_dispenser #(
    .PULSE_CYC  (4),
    .GAP_CYC    (4),
    .TIMEOUT_CYC(250),
    .MAX_BAL    (995)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // Payout observations gathered by run_payout.
  int n50, n10, n5, rises, hi_cnt, busy_cnt, done_cnt, clr_cnt, multi_cnt;
  int first_coin_k, low_k, fault_k, done_k;
  int seq[$];
  bit ack_en;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dut_if.refund_req   = 1'b0;
    dut_if.balance_in   = 10'd0;
    dut_if.hopper_empty = 3'b000;
    dut_if.hopper_ack   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Raise refund_req at a falling edge (k=0), then watch one negedge per cycle,
  // running the hopper model, until the payout completes, faults, the given
  // coin number starts (stop_at > 0), or the budget runs out.
  task automatic run_payout(input int budget, input int stop_at);
    logic [2:0] prev, cur;
    int dly;
    bit fin;
    n50 = 0; n10 = 0; n5 = 0; rises = 0; hi_cnt = 0; busy_cnt = 0;
    done_cnt = 0; clr_cnt = 0; multi_cnt = 0;
    first_coin_k = -1; low_k = -1; fault_k = -1; done_k = -1;
    seq.delete();
    prev = 3'b000;
    dly = -1;
    fin = 1'b0;
    @(negedge clk);
    dut_if.refund_req = 1'b1;
    for (int k = 1; k <= budget && !fin; k++) begin
      @(negedge clk);
      cur = {dut_if.coin50_out, dut_if.coin10_out, dut_if.coin5_out};
      if ($countones(cur) > 1) multi_cnt++;
      if (cur != 3'b000) hi_cnt++;
      if (dut_if.busy) busy_cnt++;
      if (dut_if.done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (dut_if.sum_clear) clr_cnt++;
      // hopper model
      if (ack_en && dly == 0) begin
        dut_if.hopper_ack = 1'b1;
        dly = -1;
      end else begin
        dut_if.hopper_ack = 1'b0;
        if (dly > 0) dly--;
      end
      if (cur != 3'b000 && prev == 3'b000) begin
        rises++;
        if (first_coin_k < 0) first_coin_k = k;
        case (cur)
          3'b100:  begin n50++; seq.push_back(50); end
          3'b010:  begin n10++; seq.push_back(10); end
          3'b001:  begin n5++;  seq.push_back(5);  end
          default: seq.push_back(0);
        endcase
        if (rises == stop_at) fin = 1'b1;
      end
      if (cur == 3'b000 && prev != 3'b000) begin
        if (low_k < 0) low_k = k;
        dly = 2;
      end
      if (dut_if.fault && fault_k < 0) begin
        fault_k = k;
        fin = 1'b1;
      end
      if (done_cnt > 0 && !dut_if.busy) fin = 1'b1;
      prev = cur;
    end
    dut_if.hopper_ack = 1'b0;
    check_val("finished_in_budget", 32'(fin), 32'd1);
  endtask

  initial begin
    ack_en = 1'b1;
    do_reset();

    // Reset state
    check_val("rst_coins", {29'd0, dut_if.coin50_out, dut_if.coin10_out, dut_if.coin5_out}, 32'd0);
    check_val("rst_busy", 32'(dut_if.busy), 32'd0);
    check_val("rst_done_clr", {30'd0, dut_if.done, dut_if.sum_clear}, 32'd0);
    check_val("rst_remaining", 32'(dut_if.remaining), 32'd0);
    check_val("rst_coin_cnt", 32'(dut_if.coin_cnt), 32'd0);
    check_val("rst_fault", {29'd0, dut_if.fault, dut_if.fault_code}, 32'd0);

    // 1: 65 -> 50,10,5
    dut_if.balance_in = 10'd65;
    run_payout(300, 0);
    check_val("t1_n_coins", 32'(rises), 32'd3);
    check_val("t1_seq0", 32'(seq[0]), 32'd50);
    check_val("t1_seq1", 32'(seq[1]), 32'd10);
    check_val("t1_seq2", 32'(seq[2]), 32'd5);
    check_val("t1_first_coin_lat", 32'(first_coin_k), 32'd2);
    check_val("t1_pulse_width", 32'(hi_cnt), 32'd12);
    check_val("t1_onehot", 32'(multi_cnt), 32'd0);
    check_val("t1_coin_cnt", 32'(dut_if.coin_cnt), 32'd3);
    check_val("t1_remaining", 32'(dut_if.remaining), 32'd0);
    check_val("t1_done", 32'(done_cnt), 32'd1);
    check_val("t1_sum_clear", 32'(clr_cnt), 32'd1);

    // 2: zero balance
    do_reset();
    dut_if.balance_in = 10'd0;
    run_payout(20, 0);
    check_val("t2_coins", 32'(rises), 32'd0);
    check_val("t2_done_lat", 32'(done_k), 32'd2);
    check_val("t2_busy_cycles", 32'(busy_cnt), 32'd2);
    check_val("t2_sum_clear", 32'(clr_cnt), 32'd1);

    // 3a: 60 with the 50 hopper empty
    do_reset();
    dut_if.balance_in   = 10'd60;
    dut_if.hopper_empty = 3'b100;
    run_payout(300, 0);
    check_val("t3_n10", 32'(n10), 32'd6);
    check_val("t3_n50", 32'(n50), 32'd0);
    check_val("t3_coin_cnt", 32'(dut_if.coin_cnt), 32'd6);
    check_val("t3_done", 32'(done_cnt), 32'd1);

    // 3b: 15 with 10 and 5 hoppers empty
    do_reset();
    dut_if.balance_in   = 10'd15;
    dut_if.hopper_empty = 3'b011;
    run_payout(20, 0);
    check_val("t3b_coins", 32'(rises), 32'd0);
    check_val("t3b_fault", 32'(dut_if.fault), 32'd1);
    check_val("t3b_busy", 32'(dut_if.busy), 32'd1);
    check_val("t3b_code", 32'(dut_if.fault_code), 32'd2);
    check_val("t3b_remaining", 32'(dut_if.remaining), 32'd15);
    check_val("t3b_no_clear", 32'(clr_cnt), 32'd0);

    // 4: ack never arrives, then resume
    do_reset();
    dut_if.balance_in = 10'd60;
    ack_en = 1'b0;
    run_payout(400, 0);
    check_val("t4_n50", 32'(n50), 32'd1);
    check_val("t4_coins", 32'(rises), 32'd1);
    check_val("t4_timeout_len", 32'(fault_k - low_k), 32'd250);
    check_val("t4_code", 32'(dut_if.fault_code), 32'd1);
    check_val("t4_remaining", 32'(dut_if.remaining), 32'd60);
    check_val("t4_no_clear", 32'(clr_cnt), 32'd0);
    dut_if.refund_req = 1'b0;
    @(negedge clk);
    ack_en = 1'b1;
    run_payout(300, 0);
    check_val("t4r_coins", 32'(rises), 32'd2);
    check_val("t4r_seq0", 32'(seq[0]), 32'd50);
    check_val("t4r_seq1", 32'(seq[1]), 32'd10);
    check_val("t4r_remaining", 32'(dut_if.remaining), 32'd0);
    check_val("t4r_fault", {29'd0, dut_if.fault, dut_if.fault_code}, 32'd0);
    check_val("t4r_done_clr", 32'(done_cnt * 10 + clr_cnt), 32'd11);

    // 5: 995 maximum, then level hold, then illegal 13
    do_reset();
    dut_if.balance_in = 10'd995;
    run_payout(2000, 0);
    check_val("t5_n50", 32'(n50), 32'd19);
    check_val("t5_n10", 32'(n10), 32'd4);
    check_val("t5_n5", 32'(n5), 32'd1);
    check_val("t5_coin_cnt", 32'(dut_if.coin_cnt), 32'd24);
    check_val("t5_remaining", 32'(dut_if.remaining), 32'd0);
    check_val("t5_onehot", 32'(multi_cnt), 32'd0);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut_if.busy) busy_cnt++;
    end
    check_val("t5_no_retrigger", 32'(busy_cnt), 32'd0);
    check_val("t5_cnt_holds", 32'(dut_if.coin_cnt), 32'd24);
    dut_if.refund_req = 1'b0;
    dut_if.balance_in = 10'd13;
    @(negedge clk);
    run_payout(20, 0);
    check_val("t5b_coins", 32'(rises), 32'd0);
    check_val("t5b_code", 32'(dut_if.fault_code), 32'd3);
    check_val("t5b_remaining", 32'(dut_if.remaining), 32'd13);

    // 6: reset in the middle of the second coin pulse
    do_reset();
    dut_if.balance_in = 10'd65;
    run_payout(200, 2);
    check_val("t6_second_coin_on", 32'(dut_if.coin10_out), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("t6_coins_drop", {29'd0, dut_if.coin50_out, dut_if.coin10_out, dut_if.coin5_out}, 32'd0);
    check_val("t6_busy", 32'(dut_if.busy), 32'd0);
    check_val("t6_remaining", 32'(dut_if.remaining), 32'd0);
    check_val("t6_coin_cnt", 32'(dut_if.coin_cnt), 32'd0);
    check_val("t6_flags", {28'd0, dut_if.done, dut_if.sum_clear, dut_if.fault, dut_if.fault}, 32'd0);
    dut_if.refund_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dut_if.busy) busy_cnt++;
      if (dut_if.sum_clear) clr_cnt++;
    end
    check_val("t6_idle_after", 32'(busy_cnt), 32'd0);
    check_val("t6_no_clear", 32'(clr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream of the balance calculator in the vending datapath. On a refund request it latches the current balance (0–995, multiples of 5). It then pays it out greedily as 50/10/5 coins through a pulse/acknowledge handshake with three coin hoppers, skipping empty hoppers. When the payout finishes it pulses sum_clear so the calculator zeroes its balance. Runs on the divided system clock.

Parameters:
PULSE_CYC, 4, cycles a coin_*_out line is held high per coin
GAP_CYC, 4, minimum low cycles between coins (counted only while hopper_ack is low)
TIMEOUT_CYC, 250, max cycles in WAIT_ACK before a timeout fault
MAX_BAL, 995, largest legal balance

Ports:
clk  in  1  system clock (rising edge)
reset  in  1  asynchronous, active-high
refund_req  in  1  debounced refund request, level; rising edge acts
balance_in  in  10  current balance from calculator
hopper_empty  in  3  bit2=50, bit1=10, bit0=5 hopper empty
hopper_ack  in  1  hopper confirms a coin was ejected (level)
coin50_out  out  1  eject one 50 coin
coin10_out  out  1  eject one 10 coin
coin5_out  out  1  eject one 5 coin
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at payout completion
sum_clear  out  1  one-cycle pulse coincident with done
remaining  out  10  balance still to pay
coin_cnt  out  8  coins paid in current payout
fault  out  1  high in FAULT
fault_code  out  2  00 none, 01 ack timeout, 10 no payable coin, 11 illegal balance

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters 0; edge register 0. Taking reset mid-payout drops coin lines the same instant and discards remaining.
- Edge detect: rq_d <= refund_req; edge = refund_req & ~rq_d. Level-held requests never retrigger.
- IDLE: on edge, if balance_in > MAX_BAL or balance_in % 5 != 0, go to FAULT with code 11, remaining <= balance_in, no coins. Otherwise remaining <= balance_in, coin_cnt <= 0, go to SELECT.
- SELECT (1 cycle):
  - remaining==0: go to DONE.
  - Otherwise pick the largest denomination d in {50,10,5} with d <= remaining and its hopper not empty, then go to PULSE.
  - No such d: go to FAULT, code 10.
- PULSE: the selected coin line is high for exactly PULSE_CYC cycles, starting the cycle after SELECT. Only one coin line is ever high. Then go to WAIT_ACK.
- WAIT_ACK: coin lines low.
  - hopper_ack high (including an ack that rose during PULSE and is still high): remaining <= remaining - d, coin_cnt <= coin_cnt+1, go to GAP.
  - TIMEOUT_CYC cycles without ack: go to FAULT, code 01. remaining is unchanged.
- GAP: count GAP_CYC cycles while hopper_ack is low; the counter holds while ack is high. Then go to SELECT.
- DONE: done=1 and sum_clear=1 for one cycle, then IDLE. remaining=0; coin_cnt holds until the next payout starts.
- FAULT:
  - fault=1, busy=1; remaining and coin_cnt hold.
  - A new refund edge clears fault and fault_code and resumes at SELECT with the held remaining. Exception: code 11 reloads from balance_in via the IDLE rules.
  - sum_clear is never asserted from FAULT.
- Latency: edge sampled at cycle N gives SELECT at N+1 and the first coin line high at N+2. Ideal per-coin cost is PULSE_CYC + 1 + GAP_CYC + 1 cycles.
- hopper_empty is sampled only in SELECT. A hopper that empties mid-payout is simply skipped at the next selection.
- Arithmetic: 10-bit unsigned, and the subtraction can never underflow. coin_cnt maximum is 199 (all 5s from 995), so it never wraps.

Test Plan:
1. balance_in=65, hoppers full, ack 2 cycles after each pulse ends -> coins 50,10,5 in order; coin_cnt=3; remaining=0; done and sum_clear pulse once.
2. balance_in=0, refund edge -> no coin lines; done and sum_clear pulse at N+2; busy high for 2 cycles.
3. balance_in=60, hopper_empty=3'b100 -> six 10 coins, zero 50 coins; coin_cnt=6. Separately, 15 with hopper_empty=3'b011 -> FAULT code 10, remaining=15.
4. balance_in=60, hopper_ack held low -> one 50 pulse, then FAULT code 01 after 250 cycles, remaining=60. Second refund edge with ack enabled -> 50 then 10, done, sum_clear.
5. balance_in=995 -> 19×50, 4×10, 1×5; coin_cnt=24; refund_req held high after done gives no retrigger. balance_in=13 -> FAULT code 11, no coins.
6. Reset asserted mid-PULSE of the second coin -> coin line drops immediately; all outputs 0; state IDLE; no sum_clear.
